// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with freeze (stall), flush (bubble) and a valid bit.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle WB write data into the captured operands.
module id_ex_stage_reg #(
  parameter int WordLen  = 32,
  parameter int RegAddrW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [WordLen-1:0]  pc_in,
  input  logic [WordLen-1:0]  val_rn_in,
  input  logic [WordLen-1:0]  val_rm_in,
  input  logic [RegAddrW-1:0] src1_in,
  input  logic [RegAddrW-1:0] src2_in,
  input  logic [RegAddrW-1:0] dest_in,
  input  logic [3:0]          exe_cmd_in,
  input  logic                mem_r_en_in,
  input  logic                mem_w_en_in,
  input  logic                wb_en_in,
  input  logic                b_in,
  input  logic                s_in,
  input  logic                imm_in,
  input  logic [11:0]         shift_op_in,
  input  logic [23:0]         simm24_in,
  input  logic [3:0]          status_in,
  input  logic                wb_wen,
  input  logic [RegAddrW-1:0] wb_dest,
  input  logic [WordLen-1:0]  wb_value,
  output logic [WordLen-1:0]  pc_out,
  output logic [WordLen-1:0]  val_rn_out,
  output logic [WordLen-1:0]  val_rm_out,
  output logic [RegAddrW-1:0] src1_out,
  output logic [RegAddrW-1:0] src2_out,
  output logic [RegAddrW-1:0] dest_out,
  output logic [3:0]          exe_cmd_out,
  output logic                mem_r_en_out,
  output logic                mem_w_en_out,
  output logic                wb_en_out,
  output logic                b_out,
  output logic                s_out,
  output logic                imm_out,
  output logic [11:0]         shift_op_out,
  output logic [23:0]         simm24_out,
  output logic [3:0]          status_out,
  output logic                ex_valid
);

  typedef struct packed {
    logic [WordLen-1:0]  pc;
    logic [WordLen-1:0]  val_rn;
    logic [WordLen-1:0]  val_rm;
    logic [RegAddrW-1:0] src1;
    logic [RegAddrW-1:0] src2;
    logic [RegAddrW-1:0] dest;
    logic [3:0]          exe_cmd;
    logic                mem_r_en;
    logic                mem_w_en;
    logic                wb_en;
    logic                b;
    logic                s;
    logic                imm;
    logic [11:0]         shift_op;
    logic [23:0]         simm24;
    logic [3:0]          status;
    logic                valid;
  } stage_t;

  stage_t d, q;
  logic [WordLen-1:0] rn_sel, rm_sel;

`ifdef ID_WB_BYPASS_EN
  assign rn_sel = (wb_wen && (wb_dest == src1_in)) ? wb_value : val_rn_in;
  assign rm_sel = (wb_wen && (wb_dest == src2_in)) ? wb_value : val_rm_in;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wen, wb_dest, wb_value};
  assign rn_sel    = val_rn_in;
  assign rm_sel    = val_rm_in;
`endif

  always_comb begin
    // NOTE: default the whole struct first so no field can infer a latch.
    d          = '0;
    d.pc       = pc_in;
    d.val_rn   = rn_sel;
    d.val_rm   = rm_sel;
    d.src1     = src1_in;
    d.src2     = src2_in;
    d.dest     = dest_in;
    d.exe_cmd  = exe_cmd_in;
    // A bubble must never write memory, registers, flags or redirect fetch.
    d.mem_r_en = mem_r_en_in & id_valid;
    d.mem_w_en = mem_w_en_in & id_valid;
    d.wb_en    = wb_en_in    & id_valid;
    d.b        = b_in        & id_valid;
    d.s        = s_in        & id_valid;
    d.imm      = imm_in;
    d.shift_op = shift_op_in;
    d.simm24   = simm24_in;
    d.status   = status_in;
    d.valid    = id_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so all fields update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q <= '0;
    else if (flush)   q <= '0;
    else if (!freeze) q <= d;
  end

  assign pc_out       = q.pc;
  assign val_rn_out   = q.val_rn;
  assign val_rm_out   = q.val_rm;
  assign src1_out     = q.src1;
  assign src2_out     = q.src2;
  assign dest_out     = q.dest;
  assign exe_cmd_out  = q.exe_cmd;
  assign mem_r_en_out = q.mem_r_en;
  assign mem_w_en_out = q.mem_w_en;
  assign wb_en_out    = q.wb_en;
  assign b_out        = q.b;
  assign s_out        = q.s;
  assign imm_out      = q.imm;
  assign shift_op_out = q.shift_op;
  assign simm24_out   = q.simm24;
  assign status_out   = q.status;
  assign ex_valid     = q.valid;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: a reference model pushes the expected stage contents
// when stimulus is driven; they are popped and compared one time unit after the clock edge.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic rst, freeze, flush, id_valid;
  logic [31:0] pc_in, val_rn_in, val_rm_in, wb_value;
  logic [3:0]  src1_in, src2_in, dest_in, exe_cmd_in, status_in, wb_dest;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in, wb_wen;
  logic [11:0] shift_op_in;
  logic [23:0] simm24_in;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  src1_out, src2_out, dest_out, exe_cmd_out, status_out;
  logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out, ex_valid;
  logic [11:0] shift_op_out;
  logic [23:0] simm24_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.WordLen(32), .RegAddrW(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in), .exe_cmd_in(exe_cmd_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .shift_op_in(shift_op_in),
    .simm24_in(simm24_in), .status_in(status_in),
    .wb_wen(wb_wen), .wb_dest(wb_dest), .wb_value(wb_value),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .src1_out(src1_out), .src2_out(src2_out), .dest_out(dest_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
    .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .shift_op_out(shift_op_out),
    .simm24_out(simm24_out), .status_out(status_out), .ex_valid(ex_valid)
  );

  typedef struct {
    logic [31:0] pc, rn, rm;
    logic [3:0]  src1, src2, dest, cmd, st;
    logic        mr, mw, wb, b, s, imm, v;
    logic [11:0] sh;
    logic [23:0] simm;
  } exp_t;

  exp_t model;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    check({tag, ".pc"},    pc_out,       e.pc);
    check({tag, ".rn"},    val_rn_out,   e.rn);
    check({tag, ".rm"},    val_rm_out,   e.rm);
    check({tag, ".src1"},  32'(src1_out), 32'(e.src1));
    check({tag, ".src2"},  32'(src2_out), 32'(e.src2));
    check({tag, ".dest"},  32'(dest_out), 32'(e.dest));
    check({tag, ".cmd"},   32'(exe_cmd_out), 32'(e.cmd));
    check({tag, ".mr"},    32'(mem_r_en_out), 32'(e.mr));
    check({tag, ".mw"},    32'(mem_w_en_out), 32'(e.mw));
    check({tag, ".wb"},    32'(wb_en_out), 32'(e.wb));
    check({tag, ".b"},     32'(b_out), 32'(e.b));
    check({tag, ".s"},     32'(s_out), 32'(e.s));
    check({tag, ".imm"},   32'(imm_out), 32'(e.imm));
    check({tag, ".sh"},    32'(shift_op_out), 32'(e.sh));
    check({tag, ".simm"},  32'(simm24_out), 32'(e.simm));
    check({tag, ".st"},    32'(status_out), 32'(e.st));
    check({tag, ".v"},     32'(ex_valid), 32'(e.v));
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z = '{pc: 0, rn: 0, rm: 0, src1: 0, src2: 0, dest: 0, cmd: 0, st: 0,
          mr: 0, mw: 0, wb: 0, b: 0, s: 0, imm: 0, v: 0, sh: 0, simm: 0};
    return z;
  endfunction

  // Expected register contents after the next edge, from the current ones and the inputs.
  function automatic exp_t next_state(input exp_t cur);
    exp_t n;
    if (flush) return zero_state();
    if (freeze) return cur;
    n.pc   = pc_in;
    n.rn   = val_rn_in;
    n.rm   = val_rm_in;
`ifdef ID_WB_BYPASS_EN
    if (wb_wen && wb_dest == src1_in) n.rn = wb_value;
    if (wb_wen && wb_dest == src2_in) n.rm = wb_value;
`endif
    n.src1 = src1_in;
    n.src2 = src2_in;
    n.dest = dest_in;
    n.cmd  = exe_cmd_in;
    n.st   = status_in;
    n.imm  = imm_in;
    n.sh   = shift_op_in;
    n.simm = simm24_in;
    n.v    = id_valid;
    n.mr   = id_valid ? mem_r_en_in : 1'b0;
    n.mw   = id_valid ? mem_w_en_in : 1'b0;
    n.wb   = id_valid ? wb_en_in    : 1'b0;
    n.b    = id_valid ? b_in        : 1'b0;
    n.s    = id_valid ? s_in        : 1'b0;
    return n;
  endfunction

  task automatic rand_data();
    pc_in       = $urandom;
    val_rn_in   = $urandom;
    val_rm_in   = $urandom;
    src1_in     = 4'($urandom_range(0, 14));
    src2_in     = 4'($urandom_range(0, 14));
    dest_in     = 4'($urandom_range(0, 14));
    exe_cmd_in  = 4'($urandom);
    status_in   = 4'($urandom);
    mem_r_en_in = 1'($urandom);
    mem_w_en_in = 1'($urandom);
    wb_en_in    = 1'($urandom);
    b_in        = 1'($urandom);
    s_in        = 1'($urandom);
    imm_in      = 1'($urandom);
    shift_op_in = 12'($urandom);
    simm24_in   = 24'($urandom);
    wb_wen      = 1'($urandom);
    wb_dest     = 4'($urandom_range(0, 14));
    wb_value    = $urandom;
  endtask

  // Push the expectation for the inputs now driven, clock once, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    model = next_state(model);
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp_all(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held_rn;
    logic [3:0]  held_dest;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
    rand_data();
    model = zero_state();
    #12;
    cmp_all("reset", model);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic load.
    rand_data();
    id_valid = 1'b1; val_rn_in = 32'h12; dest_in = 4'd3; wb_en_in = 1'b1; wb_wen = 1'b0;
    step("load");
    check("load.rn_const", val_rn_out, 32'h12);
    check("load.dest_const", 32'(dest_out), 32'd3);
    check("load.wb_const", 32'(wb_en_out), 32'd1);
    check("load.v_const", 32'(ex_valid), 32'd1);

    // Freeze for three edges while inputs change, then release.
    held_rn = val_rn_out;
    held_dest = dest_out;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      id_valid = 1'b1;
      step("freeze");
      check("freeze.rn_held", val_rn_out, held_rn);
      check("freeze.dest_held", 32'(dest_out), 32'(held_dest));
    end
    freeze = 1'b0;
    rand_data();
    wb_wen = 1'b0;
    val_rn_in = 32'hCAFE_0001;
    step("release");
    check("release.rn_const", val_rn_out, 32'hCAFE_0001);

    // Flush beats a simultaneous freeze.
    rand_data();
    id_valid = 1'b1; wb_en_in = 1'b1; mem_w_en_in = 1'b1; flush = 1'b1; freeze = 1'b1;
    step("flush");
    check("flush.v_const", 32'(ex_valid), 32'd0);
    check("flush.wb_const", 32'(wb_en_out), 32'd0);
    check("flush.mw_const", 32'(mem_w_en_out), 32'd0);
    flush = 1'b0; freeze = 1'b0;

    // Bubble suppresses control enables.
    rand_data();
    id_valid = 1'b0; mem_w_en_in = 1'b1; wb_en_in = 1'b1;
    step("bubble");
    check("bubble.mw_const", 32'(mem_w_en_out), 32'd0);
    check("bubble.v_const", 32'(ex_valid), 32'd0);

    // WB bypass hit and miss.
    rand_data();
    id_valid = 1'b1; src1_in = 4'd5; src2_in = 4'd7; val_rn_in = 32'h1;
    wb_wen = 1'b1; wb_dest = 4'd5; wb_value = 32'hAB;
    step("byp_hit");
`ifdef ID_WB_BYPASS_EN
    check("byp_hit.rn_const", val_rn_out, 32'hAB);
`else
    check("byp_hit.rn_const", val_rn_out, 32'h1);
`endif
    wb_dest = 4'd6;
    step("byp_miss");
    check("byp_miss.rn_const", val_rn_out, 32'h1);

    // Asynchronous reset between edges.
    rand_data();
    id_valid = 1'b1; wb_en_in = 1'b1; pc_in = 32'h4444;
    step("preload");
    #2;
    rst = 1'b1;
    #1;
    model = zero_state();
    cmp_all("async_rst", model);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic with occasional stalls and flushes.
    for (int i = 0; i < 300; i++) begin
      rand_data();
      id_valid = ($urandom_range(0, 3) != 0);
      freeze   = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    freeze = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
